// File: rtl/alu_mul_sequencer_if.sv
//------------------------------------------------------------------------------
// Module      : alu_mul_sequencer_if
// Description : Command/result handshake and shared-ALU bus of the MULTU
//               sequencer.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface alu_mul_sequencer_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] product_hi;
  logic [WIDTH-1:0] product_lo;
  logic             alu_req;
  logic             alu_gnt;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;

  // Sequencer side
  modport slave (
    input  start, multiplicand, multiplier, alu_gnt, alu_result,
    output ready, done, product_hi, product_lo, alu_req, alu_op, alu_a, alu_b
  );

  // EX stage / arbiter / ALU side
  modport master (
    output start, multiplicand, multiplier, alu_gnt, alu_result,
    input  ready, done, product_hi, product_lo, alu_req, alu_op, alu_a, alu_b
  );
endinterface

`default_nettype wire

// File: rtl/alu_mul_sequencer.sv
//------------------------------------------------------------------------------
// Module      : alu_mul_sequencer
// Description : Unsigned 32x32->64 shift-add multiplier that borrows the shared
//               EX-stage ALU for each add step. Optional early exit on an
//               exhausted multiplier: define ALU_MUL_EARLY_EXIT_EN.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_mul_sequencer #(
  parameter int         WIDTH       = 32,
  parameter logic [2:0] ALU_OP_ADD  = 3'b010,
  parameter logic [2:0] ALU_OP_IDLE = 3'b000
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_mul_sequencer_if.slave bus
);

  localparam int                CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]     c_last = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_mcand;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_product_hi;
  logic [WIDTH-1:0] r_product_lo;
  logic             w_step;
  logic             w_carry;
  logic [2*WIDTH-1:0] w_acc_step;

  // The ALU is 32-bit only, so the carry out of HI + addend is recovered here
  assign w_carry    = (bus.alu_result < r_hi);
  assign w_acc_step = {w_carry, bus.alu_result, r_lo[WIDTH-1:1]};

`ifdef ALU_MUL_EARLY_EXIT_EN
  localparam logic [CW:0] c_steps = (CW+1)'(WIDTH);

  logic               w_skip;
  logic [WIDTH-1:0]   w_pending;
  logic [CW:0]        w_shift_amt;
  logic [2*WIDTH-1:0] w_acc_skip;

  // Bits of LO still holding unprocessed multiplier bits
  assign w_pending   = r_lo & ({WIDTH{1'b1}} >> r_count);
  assign w_skip      = (r_state == S_RUN) && (w_pending == '0);
  assign w_shift_amt = c_steps - {1'b0, r_count};
  assign w_acc_skip  = {r_hi, r_lo} >> w_shift_amt;
`endif

  always_comb begin
    w_state_next = r_state;
    w_step       = 1'b0;
    bus.ready    = 1'b0;
    bus.done     = 1'b0;
    bus.alu_req  = 1'b0;
    bus.alu_op   = ALU_OP_IDLE;
    bus.alu_a    = '0;
    bus.alu_b    = '0;
    case (r_state)
      S_IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
`ifdef ALU_MUL_EARLY_EXIT_EN
        if (w_skip) begin
          w_state_next = S_DONE;
        end else
`endif
        begin
          bus.alu_req = 1'b1;
          bus.alu_op  = ALU_OP_ADD;
          bus.alu_a   = r_hi;
          bus.alu_b   = r_lo[0] ? r_mcand : '0;
          if (bus.alu_gnt) begin
            w_step = 1'b1;
            if (r_count == c_last) begin
              w_state_next = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        bus.done     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_hi         <= '0;
      r_lo         <= '0;
      r_mcand      <= '0;
      r_count      <= '0;
      r_product_hi <= '0;
      r_product_lo <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mcand <= bus.multiplicand;
            r_hi    <= '0;
            r_lo    <= bus.multiplier;
            r_count <= '0;
          end
        end
        S_RUN: begin
`ifdef ALU_MUL_EARLY_EXIT_EN
          if (w_skip) begin
            {r_hi, r_lo}                 <= w_acc_skip;
            {r_product_hi, r_product_lo} <= w_acc_skip;
          end else
`endif
          if (w_step) begin
            {r_hi, r_lo} <= w_acc_step;
            r_count      <= r_count + 1'b1;
            // Product ports change only as the final step lands
            if (r_count == c_last) begin
              {r_product_hi, r_product_lo} <= w_acc_step;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.product_hi = r_product_hi;
  assign bus.product_lo = r_product_lo;

endmodule

`default_nettype wire
